muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, placed beside the single-cycle ALU in the execute stage.
- Runs MULT, MULTU, DIV and DIVU as a 32-iteration shift-add or restoring-divide sequence. Also handles MTHI and MTLO.
- Exposes Busy so the pipeline controller stalls MFHI/MFLO and any further muldiv instruction until the result is committed.

Parameters:
None; datapath width is fixed at 32.

Ports:
- Clock  input  1  rising-edge clock
- nReset  input  1  synchronous, active-low reset
- Start  input  1  issue strobe; Func/A/B valid when high
- Func  input  6  function code, using the existing `MULT/`MULTU/`DIV/`DIVU/`MTHI/`MTLO defines; any other code is ignored
- A  input  32  rs operand (multiplicand/dividend; MTHI/MTLO data)
- B  input  32  rt operand (multiplier/divisor)
- Flush  input  1  abort in-flight operation (exception/branch squash)
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse when HI/LO updated by mult/div
- Hi  output  32  HI register
- Lo  output  32  LO register

Behaviour:
- Reset: on any edge with nReset=0, go to IDLE with Busy=0, Done=0, Hi=0, Lo=0. This applies mid-operation too; partial results are discarded.
- States: IDLE -> CALC (32 cycles) -> FIX (1 cycle) -> IDLE.
- IDLE, Start=1, Func in {MULT,MULTU,DIV,DIVU}:
  - Latch operands. Signed ops convert A and B to magnitudes and record the result signs.
  - Clear the 6-bit iteration counter, enter CALC, Busy=1 from the next cycle.
- CALC, multiply: one shift-add step per cycle on a 64-bit {acc,mplier} register, using a 33-bit add so the carry is kept.
- CALC, divide: one restoring step per cycle using a 33-bit subtract of the divisor from the partial remainder. The quotient bit is 1 when the result is non-negative.
- CALC exit: after counter reaches 31, go to FIX.
- FIX, sign correction:
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
- FIX, commit: at the end of FIX, load Hi (product[63:32] or remainder) and Lo (product[31:0] or quotient). Return to IDLE.
- Done=1 for exactly the cycle after FIX, while Busy=0. Cycle counting:
  - Start sampled at edge 0.
  - Busy=1 for cycles 1..33.
  - Hi/Lo updated and Done=1 in cycle 34.
- Divide by zero (B=0, signed or unsigned): same 34-cycle latency, FIX bypassed. Result is Lo=32'hFFFFFFFF, Hi=A.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. No trap.
- MTHI/MTLO with Start in IDLE: Hi<=A or Lo<=A at the next edge. Busy and Done stay 0.
- Start during CALC/FIX: ignored, operands not relatched. The pipeline must stall on Busy.
- Start together with Flush in IDLE: Flush wins; nothing is issued.
- Flush during CALC/FIX: return to IDLE at the next edge with Busy=0. Done is not pulsed and Hi/Lo keep their prior values.
- Flush in IDLE: no effect.
- Hi/Lo are register outputs only; no combinational path from A/B.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Busy cycles 1..33, Done in cycle 34, Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT A=0xFFFFFFFD(-3) B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Then DIV A=0xFFFFFFF9(-7) B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU A=100 B=7 -> Lo=14, Hi=2. DIVU A=0x1234 B=0 -> Lo=0xFFFFFFFF, Hi=0x1234, Done in cycle 34.
- DIV A=0x80000000 B=0xFFFFFFFF -> Lo=0x80000000, Hi=0. A second Start during Busy with different operands -> ignored, result unchanged.
- MTHI A=0xCAFEF00D -> Hi=0xCAFEF00D next cycle, Busy=0, Done=0. Then MULTU 2*3 with Flush at cycle 10 -> Busy=0 at cycle 11, no Done, Hi=0xCAFEF00D and Lo unchanged.
- nReset=0 at cycle 20 of a DIVU -> next cycle Busy=0, Hi=Lo=0, Done never asserts.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Multi-cycle multiply/divide unit holding the architectural
//             HI/LO registers. MULT/MULTU use a 32-step shift-add, and
//             DIV/DIVU use a 32-step restoring divide. One sign-fix cycle
//             follows, then the result is committed. MTHI/MTLO write HI/LO
//             directly in one cycle.
//  Ports    : Clock  - rising-edge clock
//             nReset - synchronous active-low reset
//             Start  - issue strobe (Func/A/B valid when high)
//             Func   - function code (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//             A, B   - rs / rt operands
//             Flush  - abort the in-flight operation
//             Busy   - operation in progress (pipeline stalls on it)
//             Done   - one-cycle pulse after HI/LO take a mult/div result
//             Hi, Lo - architectural HI/LO registers
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit (
   input  logic        Clock,
   input  logic        nReset,
   input  logic        Start,
   input  logic [5:0]  Func,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Flush,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   localparam logic [5:0] c_FN_MTHI  = 6'h11;
   localparam logic [5:0] c_FN_MTLO  = 6'h13;
   localparam logic [5:0] c_FN_MULT  = 6'h18;
   localparam logic [5:0] c_FN_MULTU = 6'h19;
   localparam logic [5:0] c_FN_DIV   = 6'h1A;
   localparam logic [5:0] c_FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t      state_q;
   logic [5:0]  cnt_q;
   // Multiply: {acc, mplier}.  Divide: {remainder, dividend/quotient}.
   logic [63:0] work_q;
   logic [31:0] opnd_q;      // multiplicand or divisor magnitude
   logic        is_div_q;
   logic        neg_res_q;   // operand signs differ (signed ops only)
   logic        neg_rem_q;   // dividend was negative (signed divide only)
   logic        div0_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic        w_is_md;
   logic        w_is_signed;
   logic        w_is_div;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [32:0] mul_sum_d;
   logic [63:0] mul_next_d;
   logic [32:0] div_part_d;
   logic [32:0] div_diff_d;
   logic [63:0] div_next_d;
   logic [63:0] prod_d;
   logic [31:0] quot_d;
   logic [31:0] rem_d;

   always_comb begin
      w_is_md     = (Func == c_FN_MULT) || (Func == c_FN_MULTU) ||
                    (Func == c_FN_DIV)  || (Func == c_FN_DIVU);
      w_is_signed = (Func == c_FN_MULT) || (Func == c_FN_DIV);
      w_is_div    = (Func == c_FN_DIV)  || (Func == c_FN_DIVU);
      w_a_mag     = (w_is_signed && A[31]) ? -A : A;
      w_b_mag     = (w_is_signed && B[31]) ? -B : B;

      // Shift-add step: the 33-bit sum keeps the carry, which shifts into
      // the top of the accumulator.
      mul_sum_d   = {1'b0, work_q[63:32]} + {1'b0, opnd_q};
      mul_next_d  = work_q[0] ? {mul_sum_d, work_q[31:1]}
                              : {1'b0, work_q[63:1]};

      // Restoring step: shift the next dividend bit into the remainder,
      // trial-subtract, keep the difference only when it is non-negative.
      div_part_d  = {work_q[63:32], work_q[31]};
      div_diff_d  = div_part_d - {1'b0, opnd_q};
      div_next_d  = div_diff_d[32] ? {div_part_d[31:0], work_q[30:0], 1'b0}
                                   : {div_diff_d[31:0], work_q[30:0], 1'b1};

      prod_d      = neg_res_q ? -work_q : work_q;
      quot_d      = neg_res_q ? -work_q[31:0]  : work_q[31:0];
      rem_d       = neg_rem_q ? -work_q[63:32] : work_q[63:32];
   end

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 6'd0;
         work_q    <= 64'd0;
         opnd_q    <= 32'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (Start && !Flush) begin
                  if (w_is_md) begin
                     is_div_q  <= w_is_div;
                     neg_res_q <= w_is_signed && (A[31] ^ B[31]);
                     neg_rem_q <= w_is_signed && w_is_div && A[31];
                     div0_q    <= w_is_div && (B == 32'd0);
                     work_q    <= {32'd0, w_is_div ? w_a_mag : w_b_mag};
                     opnd_q    <= w_is_div ? w_b_mag : w_a_mag;
                     cnt_q     <= 6'd0;
                     busy_q    <= 1'b1;
                     state_q   <= ST_CALC;
                  end else if (Func == c_FN_MTHI) begin
                     hi_q <= A;
                  end else if (Func == c_FN_MTLO) begin
                     lo_q <= A;
                  end
               end
            end
            ST_CALC: begin
               if (Flush) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  work_q <= is_div_q ? div_next_d : mul_next_d;
                  cnt_q  <= cnt_q + 6'd1;
                  if (cnt_q == 6'd31) begin
                     state_q <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               if (Flush) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  if (!is_div_q) begin
                     hi_q <= prod_d[63:32];
                     lo_q <= prod_d[31:0];
                  end else if (div0_q) begin
                     // Divisor zero: quotient forced to all ones; the
                     // sign-restored remainder is exactly the dividend.
                     hi_q <= rem_d;
                     lo_q <= 32'hFFFF_FFFF;
                  end else begin
                     hi_q <= rem_d;
                     lo_q <= quot_d;
                  end
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule
`default_nettype wire
